// File: rtl/memory_port_arbiter.sv
// Shares one memory port between an instruction-fetch and a load/store requester.
// One command is outstanding at a time; data wins unless fetch has waited STARVE_LIMIT grants.
module memory_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetchRequest,
  input  logic [31:0] fetchAddress,
  input  logic        fetchFlush,
  output logic        fetchGrant,
  output logic        fetchDataValid,
  output logic [31:0] fetchData,
  input  logic        dataRequest,
  input  logic        dataWrite,
  input  logic [31:0] dataAddress,
  input  logic [31:0] dataWriteData,
  input  logic [3:0]  dataByteEnable,
  output logic        dataGrant,
  output logic        dataDone,
  output logic        dataReadValid,
  output logic [31:0] dataReadData,
  output logic        memRequest,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic [3:0]  memByteEnable,
  input  logic        memResponseValid,
  input  logic [31:0] memReadData
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH_BUSY = 2'd1,
    DATA_BUSY  = 2'd2
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       drop_q, drop_d;
  logic       write_q, write_d;

  // State register plus starvation counter, flush-drop flag and outstanding-write flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
      drop_q   <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
      write_q  <= write_d;
    end
  end

  // Arbitration, memory command mux and response steering
  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    drop_d         = drop_q;
    write_d        = write_q;
    fetchGrant     = 1'b0;
    fetchDataValid = 1'b0;
    fetchData      = 32'd0;
    dataGrant      = 1'b0;
    dataDone       = 1'b0;
    dataReadValid  = 1'b0;
    dataReadData   = 32'd0;
    memRequest     = 1'b0;
    memWrite       = 1'b0;
    memAddress     = 32'd0;
    memWriteData   = 32'd0;
    memByteEnable  = 4'd0;
    if (reset) begin
      state_d  = IDLE;
      starve_d = 4'd0;
      drop_d   = 1'b0;
      write_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dataRequest && ((starve_q < LIMIT) || !fetchRequest)) begin
            dataGrant     = 1'b1;
            memRequest    = 1'b1;
            memWrite      = dataWrite;
            memAddress    = dataAddress;
            memWriteData  = dataWriteData;
            memByteEnable = dataByteEnable;
            write_d       = dataWrite;
            state_d       = DATA_BUSY;
            // Only reachable with fetch waiting when below the limit, so this saturates
            if (fetchRequest) begin
              starve_d = starve_q + 4'd1;
            end else begin
              starve_d = 4'd0;
            end
          end else if (fetchRequest && !fetchFlush) begin
            fetchGrant    = 1'b1;
            memRequest    = 1'b1;
            memAddress    = fetchAddress;
            memByteEnable = 4'hF;
            starve_d      = 4'd0;
            state_d       = FETCH_BUSY;
          end else if (!fetchRequest) begin
            starve_d = 4'd0;
          end else begin
            starve_d = starve_q;
          end
        end
        FETCH_BUSY: begin
          if (memResponseValid) begin
            state_d = IDLE;
            drop_d  = 1'b0;
            if (!drop_q && !fetchFlush) begin
              fetchDataValid = 1'b1;
              fetchData      = memReadData;
            end else begin
              fetchDataValid = 1'b0;
            end
          end else if (fetchFlush) begin
            drop_d = 1'b1;
          end else begin
            drop_d = drop_q;
          end
        end
        DATA_BUSY: begin
          if (memResponseValid) begin
            state_d  = IDLE;
            dataDone = 1'b1;
            if (!write_q) begin
              dataReadValid = 1'b1;
              dataReadData  = memReadData;
            end else begin
              dataReadValid = 1'b0;
            end
          end else begin
            state_d = DATA_BUSY;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_memory_port_arbiter;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetchRequest;
  logic [31:0] fetchAddress;
  logic        fetchFlush;
  logic        fetchGrant;
  logic        fetchDataValid;
  logic [31:0] fetchData;
  logic        dataRequest;
  logic        dataWrite;
  logic [31:0] dataAddress;
  logic [31:0] dataWriteData;
  logic [3:0]  dataByteEnable;
  logic        dataGrant;
  logic        dataDone;
  logic        dataReadValid;
  logic [31:0] dataReadData;
  logic        memRequest;
  logic        memWrite;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [3:0]  memByteEnable;
  logic        memResponseValid;
  logic [31:0] memReadData;

  int tests_run = 0;
  int tests_failed = 0;

  memory_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .fetchRequest(fetchRequest), .fetchAddress(fetchAddress), .fetchFlush(fetchFlush),
    .fetchGrant(fetchGrant), .fetchDataValid(fetchDataValid), .fetchData(fetchData),
    .dataRequest(dataRequest), .dataWrite(dataWrite), .dataAddress(dataAddress),
    .dataWriteData(dataWriteData), .dataByteEnable(dataByteEnable),
    .dataGrant(dataGrant), .dataDone(dataDone), .dataReadValid(dataReadValid),
    .dataReadData(dataReadData),
    .memRequest(memRequest), .memWrite(memWrite), .memAddress(memAddress),
    .memWriteData(memWriteData), .memByteEnable(memByteEnable),
    .memResponseValid(memResponseValid), .memReadData(memReadData)
  );

  always #5 clock = ~clock;

  function automatic logic [138:0] out_vec();
    return {fetchGrant, fetchDataValid, fetchData, dataGrant, dataDone, dataReadValid,
            dataReadData, memRequest, memWrite, memAddress, memWriteData, memByteEnable};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    fetchRequest = 1'b0; fetchAddress = 32'd0; fetchFlush = 1'b0;
    dataRequest = 1'b0; dataWrite = 1'b0; dataAddress = 32'd0;
    dataWriteData = 32'd0; dataByteEnable = 4'd0;
    memResponseValid = 1'b0; memReadData = 32'd0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    fetchRequest = 1'b1; dataRequest = 1'b1; memResponseValid = 1'b1;
    tick();
    #2;
    tests_run++;
    if (out_vec() !== 139'd0) begin
      tests_failed++;
      $display("FAIL reset_priority: outputs %h required 0", out_vec());
    end
    reset = 1'b0;
    clear_inputs();
    tick();
    #2;
    tests_run++;
    if (out_vec() !== 139'd0) begin
      tests_failed++;
      $display("FAIL reset_idle: outputs %h required 0", out_vec());
    end
  endtask

  task automatic test_fetch_basic();
    apply_reset();
    fetchRequest = 1'b1; fetchAddress = 32'h100;
    #2;
    tests_run++;
    if ({fetchGrant, dataGrant, memRequest, memWrite, memAddress, memWriteData, memByteEnable}
        !== {1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF}) begin
      tests_failed++;
      $display("FAIL fetch_grant: fg=%0b dg=%0b mr=%0b mw=%0b ma=%h mwd=%h be=%h required 1 0 1 0 100 0 f",
               fetchGrant, dataGrant, memRequest, memWrite, memAddress, memWriteData, memByteEnable);
    end
    for (int c = 1; c < 3; c++) begin
      tick();
      fetchRequest = 1'b0; fetchAddress = 32'h0;
      #2;
      tests_run++;
      if (out_vec() !== 139'd0) begin
        tests_failed++;
        $display("FAIL fetch_busy_quiet: cycle %0d outputs %h required 0", c, out_vec());
      end
    end
    tick();
    memResponseValid = 1'b1; memReadData = 32'h00000013;
    #2;
    tests_run++;
    if ({fetchDataValid, fetchData, memRequest} !== {1'b1, 32'h00000013, 1'b0}) begin
      tests_failed++;
      $display("FAIL fetch_return: fdv=%0b fd=%h mr=%0b required 1 00000013 0",
               fetchDataValid, fetchData, memRequest);
    end
    tick();
    memResponseValid = 1'b0; memReadData = 32'hFFFFFFFF;
    #2;
    tests_run++;
    if ({fetchDataValid, fetchData} !== {1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL fetch_return_clear: fdv=%0b fd=%h required 0 0", fetchDataValid, fetchData);
    end
  endtask

  task automatic test_starvation();
    int seq[10];
    int ng = 0;
    int got;
    int cnt = 0;
    int expk;
    logic resp = 1'b0;
    apply_reset();
    fetchRequest = 1'b1; fetchAddress = 32'h400;
    dataRequest = 1'b1; dataAddress = 32'h800;
    for (int c = 0; c < 20; c++) begin
      memResponseValid = resp;
      memReadData = $urandom;
      #2;
      got = dataGrant ? 1 : (fetchGrant ? 2 : 0);
      if (dataGrant && fetchGrant) got = 3;
      if (got != 0) begin
        if (ng < 10) seq[ng] = got;
        ng++;
      end
      resp = (got != 0);
      tick();
    end
    clear_inputs();
    tests_run++;
    if (ng != 10) begin
      tests_failed++;
      $display("FAIL starve_grant_count: got %0d grants required 10", ng);
    end
    for (int k = 0; k < 10; k++) begin
      if (cnt < LIMIT) begin
        expk = 1;
        cnt++;
      end else begin
        expk = 2;
        cnt = 0;
      end
      tests_run++;
      if (k >= ng || seq[k] != expk) begin
        tests_failed++;
        $display("FAIL starve_order: grant %0d got %0d required %0d (1=data 2=fetch)",
                 k, (k < ng) ? seq[k] : 0, expk);
      end
    end
  endtask

  task automatic test_data_access();
    logic [31:0] rd;
    apply_reset();
    dataRequest = 1'b1; dataWrite = 1'b1; dataAddress = 32'h200;
    dataWriteData = 32'hDEADBEEF; dataByteEnable = 4'b0011;
    #2;
    tests_run++;
    if ({dataGrant, fetchGrant, memRequest, memWrite, memAddress, memWriteData, memByteEnable}
        !== {1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'b0011}) begin
      tests_failed++;
      $display("FAIL data_write_cmd: dg=%0b fg=%0b mr=%0b mw=%0b ma=%h mwd=%h be=%h required 1 0 1 1 200 deadbeef 3",
               dataGrant, fetchGrant, memRequest, memWrite, memAddress, memWriteData, memByteEnable);
    end
    tick();
    clear_inputs();
    memResponseValid = 1'b1; memReadData = 32'hA5A5A5A5;
    #2;
    tests_run++;
    if ({dataDone, dataReadValid, dataReadData} !== {1'b1, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL data_write_done: dd=%0b drv=%0b drd=%h required 1 0 0",
               dataDone, dataReadValid, dataReadData);
    end
    tick();
    rd = $urandom;
    memResponseValid = 1'b0;
    dataRequest = 1'b1; dataWrite = 1'b0; dataAddress = 32'h204; dataByteEnable = 4'hF;
    #2;
    tests_run++;
    if ({dataDone, dataGrant, memWrite, memAddress} !== {1'b0, 1'b1, 1'b0, 32'h204}) begin
      tests_failed++;
      $display("FAIL data_read_cmd: dd=%0b dg=%0b mw=%0b ma=%h required 0 1 0 204",
               dataDone, dataGrant, memWrite, memAddress);
    end
    tick();
    clear_inputs();
    dataWrite = 1'b1;
    memResponseValid = 1'b1; memReadData = rd;
    #2;
    tests_run++;
    if ({dataDone, dataReadValid, dataReadData} !== {1'b1, 1'b1, rd}) begin
      tests_failed++;
      $display("FAIL data_read_return: dd=%0b drv=%0b drd=%h required 1 1 %h",
               dataDone, dataReadValid, dataReadData, rd);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_flush();
    apply_reset();
    fetchRequest = 1'b1; fetchAddress = 32'h300;
    #2;
    tests_run++;
    if (fetchGrant !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_first_grant: fg=%0b required 1", fetchGrant);
    end
    tick();
    fetchRequest = 1'b0; fetchFlush = 1'b1;
    tick();
    fetchFlush = 1'b0;
    tick();
    fetchRequest = 1'b1; fetchAddress = 32'h304;
    memResponseValid = 1'b1; memReadData = 32'h12345678;
    #2;
    tests_run++;
    if ({fetchDataValid, fetchData, fetchGrant} !== {1'b0, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL flush_drop: fdv=%0b fd=%h fg=%0b required 0 0 0",
               fetchDataValid, fetchData, fetchGrant);
    end
    tick();
    memResponseValid = 1'b0;
    #2;
    tests_run++;
    if ({fetchGrant, memAddress} !== {1'b1, 32'h304}) begin
      tests_failed++;
      $display("FAIL flush_next_grant: fg=%0b ma=%h required 1 304", fetchGrant, memAddress);
    end
    tick();
    fetchRequest = 1'b0;
    memResponseValid = 1'b1; memReadData = 32'hCAFEF00D;
    #2;
    tests_run++;
    if ({fetchDataValid, fetchData} !== {1'b1, 32'hCAFEF00D}) begin
      tests_failed++;
      $display("FAIL flush_recovered: fdv=%0b fd=%h required 1 cafef00d", fetchDataValid, fetchData);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    dataRequest = 1'b1; dataWrite = 1'b0; dataAddress = 32'h500; dataByteEnable = 4'hF;
    tick();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    memResponseValid = 1'b1; memReadData = 32'h55AA55AA;
    #2;
    tests_run++;
    if (out_vec() !== 139'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_discard: outputs %h required 0", out_vec());
    end
    tick();
    memResponseValid = 1'b0;
    dataRequest = 1'b1; dataAddress = 32'h504;
    #2;
    tests_run++;
    if ({dataGrant, memAddress} !== {1'b1, 32'h504}) begin
      tests_failed++;
      $display("FAIL reset_mid_idle: dg=%0b ma=%h required 1 504", dataGrant, memAddress);
    end
    tick();
    clear_inputs();
    memResponseValid = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_idle_response();
    apply_reset();
    memResponseValid = 1'b1; memReadData = 32'h77777777;
    #2;
    tests_run++;
    if (out_vec() !== 139'd0) begin
      tests_failed++;
      $display("FAIL idle_response: outputs %h required 0", out_vec());
    end
    tick();
    memResponseValid = 1'b0;
    fetchRequest = 1'b1; fetchAddress = 32'h600;
    #2;
    tests_run++;
    if ({fetchGrant, memAddress} !== {1'b1, 32'h600}) begin
      tests_failed++;
      $display("FAIL idle_response_state: fg=%0b ma=%h required 1 600", fetchGrant, memAddress);
    end
    tick();
    clear_inputs();
    memResponseValid = 1'b1;
    tick();
    clear_inputs();
  endtask

  // Transaction-level model: who owns the port, how many data grants fetch has waited.
  task automatic test_random();
    int owner = 0;            // 0 free, 1 fetch outstanding, 2 data outstanding
    bit pending_write = 0;
    bit drop = 0;
    int waited = 0;
    logic [138:0] exp_v;
    logic e_fg, e_fdv, e_dg, e_dd, e_drv, e_mr, e_mw;
    logic [31:0] e_fd, e_drd, e_ma, e_mwd;
    logic [3:0] e_be;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      fetchRequest     = ($urandom_range(0, 3) != 0);
      fetchAddress     = $urandom;
      fetchFlush       = ($urandom_range(0, 7) == 0);
      dataRequest      = ($urandom_range(0, 3) != 0);
      dataWrite        = $urandom_range(0, 1);
      dataAddress      = $urandom;
      dataWriteData    = $urandom;
      dataByteEnable   = 4'($urandom_range(0, 15));
      memResponseValid = ($urandom_range(0, 2) == 0);
      memReadData      = $urandom;
      #2;
      {e_fg, e_fdv, e_dg, e_dd, e_drv, e_mr, e_mw} = 7'd0;
      e_fd = 32'd0; e_drd = 32'd0; e_ma = 32'd0; e_mwd = 32'd0; e_be = 4'd0;
      if (owner == 0) begin
        if (dataRequest && (waited < LIMIT || !fetchRequest)) begin
          e_dg = 1'b1; e_mr = 1'b1; e_mw = dataWrite; e_ma = dataAddress;
          e_mwd = dataWriteData; e_be = dataByteEnable;
          owner = 2; pending_write = dataWrite;
          waited = fetchRequest ? waited + 1 : 0;
        end else if (fetchRequest && !fetchFlush) begin
          e_fg = 1'b1; e_mr = 1'b1; e_ma = fetchAddress; e_be = 4'hF;
          owner = 1; waited = 0;
        end else if (!fetchRequest) begin
          waited = 0;
        end
      end else if (owner == 1) begin
        if (memResponseValid) begin
          if (!drop && !fetchFlush) begin
            e_fdv = 1'b1; e_fd = memReadData;
          end
          drop = 0; owner = 0;
        end else if (fetchFlush) begin
          drop = 1;
        end
      end else begin
        if (memResponseValid) begin
          e_dd = 1'b1;
          if (!pending_write) begin
            e_drv = 1'b1; e_drd = memReadData;
          end
          owner = 0;
        end
      end
      exp_v = {e_fg, e_fdv, e_fd, e_dg, e_dd, e_drv, e_drd, e_mr, e_mw, e_ma, e_mwd, e_be};
      tests_run++;
      if (out_vec() !== exp_v) begin
        tests_failed++;
        $display("FAIL random_cycle %0d: outputs %h required %h", c, out_vec(), exp_v);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    tick();
    test_reset();
    test_fetch_basic();
    test_starvation();
    test_data_access();
    test_flush();
    test_reset_mid_access();
    test_idle_response();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
